fetch_stage: RTL

- Instruction-fetch stage of the RV32I core. Directly upstream of the instruction ROM.
- Owns the program counter and drives `pc_f` to the ROM. The ROM returns `instr_f` combinationally in the same cycle.
- Captures `{instr, pc, pc+4}` into the IF/ID pipeline register for decode.
- Handles stall (hazard unit) and redirect (branch/jump resolved in EX), which flushes the IF/ID register.

---
 rtl/core_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/if_id_reg.sv | 27 ++
 rtl/fetch_stage.sv | 68 ++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core types and constants: the IF/ID pipeline word, the bubble
// encoding and the reset fetch address.
package core_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       32'h0,
        pc_plus4: 32'h0,
        valid:    1'b0
    };

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: hazard unit, EX
// redirect, instruction ROM and the decode-facing IF/ID register.
interface fetch_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_target, instr_f,
        output pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_err, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_target, instr_f,
        input  pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_err, fetch_count
    );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register: flush loads the bubble and beats enable; en=0
// holds. Reused for ID/EX with a different payload type.
module if_id_reg
    import core_pkg::*;
#(
    parameter type T         = if_id_t,
    parameter T    RESET_VAL = IF_ID_BUBBLE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic flush,
    input  T     d,
    output T     q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, feeds the ROM and fills IF/ID,
// with redirect taking precedence over stall.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam if_id_t BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       32'h0,
        pc_plus4: 32'h0,
        valid:    1'b0
    };

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] count;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    assign pc_plus4 = pc + 32'd4;
    assign if_id_d  = '{instr: bus.instr_f, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
            count    <= 32'h0;
        end else if (bus.redirect_valid) begin
            // Low bits are dropped so the ROM only ever sees aligned addresses.
            pc <= word_align(bus.redirect_target);
            if (bus.redirect_target[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else if (!bus.stall) begin
            pc    <= pc_plus4;
            count <= count + 32'd1;
        end
    end

    if_id_reg #(
        .T         (if_id_t),
        .RESET_VAL (BUBBLE)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .en    (!bus.stall),
        .flush (bus.redirect_valid),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign bus.pc_f         = pc;
    assign bus.instr_d      = if_id_q.instr;
    assign bus.pc_d         = if_id_q.pc;
    assign bus.pc_plus4_d   = if_id_q.pc_plus4;
    assign bus.valid_d      = if_id_q.valid;
    assign bus.misalign_err = misalign;
    assign bus.fetch_count  = count;

endmodule
